uart_frame_arbiter: RTL

Shares one UartFrameDatas transmit path between several requesters that each need to send a full multi-byte frame.
- Round-robin grant; latches the winner's frame and issues the single-cycle send request.
- Waits for send-done, then acknowledges the owner.
- Optional watchdog recovers from a UART that never reports done.
- Sits between application logic and the UartFrameDatas instance; the receive side is not touched.

---
 rtl/uart_frame_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - round-robin owner of one UartFrameDatas transmit path
// Latches the winner's frame, pulses the send request, waits for done or watchdog, acks.
module uart_frame_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int BYTES      = 8,
  parameter int TIMEOUT    = 0
) (
  input  logic                          iClock,
  input  logic                          iNreset,
  input  logic [REQUESTERS-1:0]         iReq,
  input  logic [REQUESTERS*BYTES*8-1:0] iDatas,
  output logic [REQUESTERS-1:0]         oGrant,
  output logic [REQUESTERS-1:0]         oAck,
  output logic                          oTimeout,
  output logic                          oBusy,
  output logic                          oSendReq,
  output logic [BYTES*8-1:0]            oSendDatas,
  input  logic                          iSendBusy,
  input  logic                          iSendDone
);

  localparam int DW = BYTES * 8;
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [REQUESTERS-1:0]   ack_q, ack_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic                    send_req_q, send_req_d;
  logic [DW-1:0]           datas_q, datas_d;
  logic [31:0]             wd_q, wd_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           owner_q, owner_d;

  logic                    found;
  logic [PW-1:0]           win;
  logic [PW-1:0]           cand;
  logic                    wd_expired;
  logic                    can_grant;

  // Scan upward from the slot after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      cand = PW'((int'(ptr_q) + i) % REQUESTERS);
      if (!found && iReq[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign wd_expired = (TIMEOUT > 0) && (wd_q == WD_LAST);
  assign can_grant  = found && !iSendBusy;

  always_ff @(posedge iClock or negedge iNreset) begin
    if (!iNreset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      send_req_q <= 1'b0;
      datas_q    <= '0;
      wd_q       <= '0;
      ptr_q      <= PW'(REQUESTERS - 1);
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      send_req_q <= send_req_d;
      datas_q    <= datas_d;
      wd_q       <= wd_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (can_grant) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (iSendDone || wd_expired) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the ack/timeout pair is loaded on entry to DONE.
  always_comb begin
    grant_d    = grant_q;
    ack_d      = '0;
    timeout_d  = 1'b0;
    busy_d     = busy_q;
    send_req_d = 1'b0;
    datas_d    = datas_q;
    wd_d       = wd_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    case (state_q)
      S_IDLE: begin
        if (can_grant) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          datas_d      = iDatas[int'(win)*DW +: DW];
          busy_d       = 1'b1;
          send_req_d   = 1'b1;
        end
      end
      S_START: wd_d = '0;
      S_WAIT: begin
        wd_d = wd_q + 32'd1;
        if (iSendDone || wd_expired) begin
          ack_d     = grant_q;
          timeout_d = !iSendDone;
        end
      end
      S_DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = owner_q;
      end
      default: ;
    endcase
  end

  assign oGrant     = grant_q;
  assign oAck       = ack_q;
  assign oTimeout   = timeout_q;
  assign oBusy      = busy_q;
  assign oSendReq   = send_req_q;
  assign oSendDatas = datas_q;

endmodule
